// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request/result valid-ready bundle for alu_multicycle
interface alu_multicycle_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic             is_lui;
    logic             is_i_type;
    logic [3:0]       alu_ops;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  rd_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, is_lui, is_i_type, alu_ops, rs1_data, rs2_data, imm, in_tag, out_ready,
        input  in_ready, out_valid, rd_data, out_tag
    );

    modport slave (
        input  in_valid, is_lui, is_i_type, alu_ops, rs1_data, rs2_data, imm, in_tag, out_ready,
        output in_ready, out_valid, rd_data, out_tag
    );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked execute ALU with iterative mul/divu and tag pass-through
// ALU_FAST_MUL_EN selects a single-cycle combinational multiplier instead of shift-add.
module alu_multicycle #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    alu_multicycle_if.slave  bus,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    localparam int CW = $clog2(XLEN);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [XLEN-1:0]  opa, opb, acc, rd_q;
    logic [TAG_W-1:0] tag_q;
    logic             vld_q;
    logic [XLEN-1:0]  simple, mul_acc_n, div_rem_n, div_q_n;
    logic [XLEN:0]    div_sh, div_diff;
    logic             div_ge, is_alu, is_mul, is_div, go_mul, accept, last;

    assign is_alu = !bus.is_lui && !bus.is_i_type;
    assign is_mul = is_alu && bus.alu_ops == OP_MUL;
    assign is_div = is_alu && bus.alu_ops == OP_DIVU;
`ifdef ALU_FAST_MUL_EN
    assign go_mul = 1'b0;
`else
    assign go_mul = is_mul;
`endif

    assign bus.in_ready  = !flush && (state == IDLE || (state == DONE && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign busy          = state == MUL || state == DIV;
    assign last          = cnt == CW'(XLEN - 1);
    assign bus.out_valid = vld_q;
    assign bus.rd_data   = rd_q;
    assign bus.out_tag   = tag_q;

    always_comb begin
        simple = bus.is_lui                ? bus.imm << 12 :
                 bus.is_i_type             ? bus.rs1_data + bus.imm :
                 bus.alu_ops == OP_ADD     ? bus.rs1_data + bus.rs2_data :
                 bus.alu_ops == OP_SUB     ? bus.rs1_data - bus.rs2_data :
`ifdef ALU_FAST_MUL_EN
                 is_mul                    ? bus.rs1_data * bus.rs2_data :
`endif
                 '0;
    end

    // mul: acc accumulates opa (multiplicand, shifting left) per set bit of opb.
    // divu: acc is the partial remainder, opa shifts dividend out and quotient in.
    always_comb begin
        mul_acc_n = acc + (opb[0] ? opa : '0);
        div_sh    = {acc, opa[XLEN-1]};
        div_diff  = div_sh - {1'b0, opb};
        div_ge    = div_sh >= {1'b0, opb};
        div_rem_n = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
        div_q_n   = {opa[XLEN-2:0], div_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            rd_q  <= '0;
            tag_q <= '0;
            vld_q <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
            vld_q <= 1'b0;
        end else if (accept) begin
            tag_q <= bus.in_tag;
            opa   <= bus.rs1_data;
            opb   <= bus.rs2_data;
            acc   <= '0;
            cnt   <= '0;
            if (go_mul) begin
                state <= MUL;
                vld_q <= 1'b0;
            end else if (is_div) begin
                state <= DIV;
                vld_q <= 1'b0;
            end else begin
                state <= DONE;
                rd_q  <= simple;
                vld_q <= 1'b1;
            end
        end else begin
            case (state)
                MUL: begin
                    acc <= mul_acc_n;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        state <= DONE;
                        rd_q  <= mul_acc_n;
                        vld_q <= 1'b1;
                        cnt   <= '0;
                    end
                end
                DIV: begin
                    acc <= div_rem_n;
                    opa <= div_q_n;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        state <= DONE;
                        rd_q  <= div_q_n;
                        vld_q <= 1'b1;
                        cnt   <= '0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                        vld_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed + random checks of alu_multicycle against an arithmetic model
module tb_alu_multicycle;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef ALU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_multicycle_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    alu_multicycle #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model(input logic lui, input logic itype, input logic [3:0] ops,
                                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [XLEN-1:0] imm);
        if (lui) return imm << 12;
        if (itype) return a + imm;
        case (ops)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd12:   return a * b;
            4'd13:   return (b == 0) ? '1 : a / b;
            default: return '0;
        endcase
    endfunction

    function automatic int lat_of(input logic lui, input logic itype, input logic [3:0] ops);
        if (!lui && !itype && ops == 4'd12) return MUL_LAT;
        if (!lui && !itype && ops == 4'd13) return DIV_LAT;
        return 1;
    endfunction

    task automatic drive(input logic lui, input logic itype, input logic [3:0] ops, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm, input logic [TAG_W-1:0] tag);
        bus.is_lui    = lui;
        bus.is_i_type = itype;
        bus.alu_ops   = ops;
        bus.rs1_data  = a;
        bus.rs2_data  = b;
        bus.imm       = imm;
        bus.in_tag    = tag;
        bus.in_valid  = 1'b1;
    endtask

    task automatic run_op(input string name, input logic lui, input logic itype, input logic [3:0] ops,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm,
                          input logic [TAG_W-1:0] tag);
        int cyc;
        logic [XLEN-1:0] exp;
        exp = model(lui, itype, ops, a, b, imm);
        @(negedge clk);
        drive(lui, itype, ops, a, b, imm, tag);
        bus.out_ready = 1'b1;
        #1 check({name, "_in_ready"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_lat"}, cyc, lat_of(lui, itype, ops));
        check({name, "_data"}, bus.rd_data, exp);
        check({name, "_tag"}, bus.out_tag, tag);
    endtask

    initial begin
        int cyc;
        logic seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        bus.in_valid  = 1'b0;
        #3;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_out_tag", bus.out_tag, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // back-to-back: add then sub accepted in the result cycle
        @(negedge clk);
        drive(0, 0, 4'd0, 5, 7, 0, 5'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("b2b_add_valid", bus.out_valid, 1);
        check("b2b_add_data", bus.rd_data, 12);
        check("b2b_add_tag", bus.out_tag, 1);
        drive(0, 0, 4'd1, 3, 5, 0, 5'd2);
        #1 check("b2b_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("b2b_sub_valid", bus.out_valid, 1);
        check("b2b_sub_data", bus.rd_data, 32'hFFFF_FFFE);
        check("b2b_sub_tag", bus.out_tag, 2);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_idle", bus.out_valid, 0);

        run_op("mul_wrap", 0, 0, 4'd12, 32'h1_0000, 32'h1_0000, 0, 5'd3);
        run_op("mul_7x6", 0, 0, 4'd12, 7, 6, 0, 5'd4);
        run_op("divu_100_7", 0, 0, 4'd13, 100, 7, 0, 5'd5);
        run_op("divu_by0", 0, 0, 4'd13, 5, 0, 0, 5'd6);
        run_op("lui_wrap", 1, 1, 4'd12, 1, 2, 32'hFFF8_1234, 5'd7);
        run_op("itype", 0, 1, 4'd13, 32'hFFFF_FFF0, 9, 32'h20, 5'd8);
        run_op("bad_op", 0, 0, 4'd5, 9, 9, 9, 5'd9);

        // backpressure: result held, new request waits for out_ready
        @(negedge clk);
        drive(0, 0, 4'd13, 100, 7, 0, 5'd7);
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_lat", cyc, DIV_LAT);
        drive(0, 0, 4'd0, 1, 2, 0, 5'd4);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_hold_data", bus.rd_data, 14);
            check("bp_hold_tag", bus.out_tag, 7);
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_next_valid", bus.out_valid, 1);
        check("bp_next_data", bus.rd_data, 3);
        check("bp_next_tag", bus.out_tag, 4);
        @(negedge clk);
        check("bp_idle", bus.out_valid, 0);

        // flush in cycle 10 of divu; a request in the flush cycle is dropped
        drive(0, 0, 4'd13, 1000, 3, 0, 5'd3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        drive(0, 0, 4'd0, 1, 1, 0, 5'd1);
        #1 check("flush_in_ready", bus.in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("flush_after_ready", bus.in_ready, 1);
        check("flush_after_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_no_valid", seen, 0);
        run_op("lui", 1, 0, 4'd0, 0, 0, 32'h12345, 5'd10);

        // async reset mid-mul
        @(negedge clk);
        drive(0, 0, 4'd12, 32'h1234, 32'h5678, 0, 5'd9);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
`ifndef ALU_FAST_MUL_EN
        check("mul_busy", busy, 1);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_rd_data", bus.rd_data, 0);
        check("arst_out_tag", bus.out_tag, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_add", 0, 0, 4'd0, 1, 1, 0, 5'd11);

        for (int i = 0; i < 30; i++) begin
            int sel;
            logic lui, itype;
            logic [3:0] ops;
            logic [XLEN-1:0] b;
            sel   = $urandom_range(0, 5);
            lui   = (sel == 5) && $urandom_range(0, 1) == 1;
            itype = (sel == 5) && !lui;
            ops   = (sel == 0) ? 4'd0 : (sel == 1) ? 4'd1 : (sel == 2) ? 4'd12 :
                    (sel == 3) ? 4'd13 : 4'($urandom);
            b     = $urandom_range(0, 1) == 1 ? 32'($urandom_range(0, 20)) : 32'($urandom);
            run_op("rand", lui, itype, ops, $urandom, b, $urandom, 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
